// File: rtl/banco_registros_pkg.sv
// Shared datapath constants and types for the RISC-V integer register file.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_X0 = '0;

  typedef logic [XLEN-1:0] reg_word_t;

endpackage

// File: rtl/banco_registros_if.sv
// Write-back and operand-read bus of the register file.
interface banco_registros_if #(
  parameter int unsigned XLEN = rv_pkg::XLEN,
  parameter int unsigned AW   = rv_pkg::AW
) ();

  logic            WE;
  logic [AW-1:0]   WA;
  logic [XLEN-1:0] WD;
  logic [AW-1:0]   RA1;
  logic [AW-1:0]   RA2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;

  modport master (
    output WE, WA, WD, RA1, RA2,
    input  RD1, RD2
  );

  modport slave (
    input  WE, WA, WD, RA1, RA2,
    output RD1, RD2
  );

endinterface

// File: rtl/banco_registros_rf_read_port.sv
// One combinational read port: x0 check, write-back bypass, storage select.
module rf_read_port
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned NREG   = rv_pkg::NREG,
  parameter int unsigned AW     = rv_pkg::AW,
  parameter int unsigned BYPASS = 1
) (
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] regs [NREG],
  output logic [XLEN-1:0] rd_c
);

  logic bypass_hit;

  // Forward the in-flight write unless reset is discarding it this cycle.
  assign bypass_hit = (BYPASS != 0) && we && !rst && (wa == ra);

  // x0 wins over everything, then bypass, then stored contents.
  always_comb begin
    rd_c = '0;
    if (ra == AW'(REG_X0)) begin
      rd_c = '0;
    end else if (bypass_hit) begin
      rd_c = wd;
    end else begin
      rd_c = regs[ra];
    end
  end

endmodule

// File: rtl/banco_registros.sv
// 32x32 integer register file: two combinational reads, one synchronous write.
module banco_registros
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned NREG   = rv_pkg::NREG,
  parameter int unsigned AW     = rv_pkg::AW,
  parameter int unsigned BYPASS = 1
) (
  input  logic               CLK,
  input  logic               RST,
  banco_registros_if.slave   rf
);

  // Entry 0 carries no storage; it is supplied as a constant in the view below.
  logic [XLEN-1:0] mem  [1:NREG-1];
  logic [XLEN-1:0] regs [NREG];

  // Reset clears every entry and overrides any write in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i < int'(NREG); i++) begin
        mem[i] <= '0;
      end
    end else if (rf.WE && (rf.WA != AW'(REG_X0))) begin
      mem[rf.WA] <= rf.WD;
    end
  end

  // Full-size view of storage with x0 pinned to zero for the read ports.
  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < int'(NREG); i++) begin
      regs[i] = mem[i];
    end
  end

  rf_read_port #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)
  ) u_port1 (
    .rst  (RST),
    .we   (rf.WE),
    .wa   (rf.WA),
    .wd   (rf.WD),
    .ra   (rf.RA1),
    .regs (regs),
    .rd_c (rf.RD1)
  );

  rf_read_port #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)
  ) u_port2 (
    .rst  (RST),
    .we   (rf.WE),
    .wa   (rf.WA),
    .wd   (rf.WD),
    .ra   (rf.RA2),
    .regs (regs),
    .rd_c (rf.RD2)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench: bypassing and non-bypassing register files driven in lockstep.
module tb_banco_registros;

  logic        CLK;
  logic        t_rst;
  logic        t_we;
  logic [4:0]  t_wa;
  logic [31:0] t_wd;
  logic [4:0]  t_ra1;
  logic [4:0]  t_ra2;

  logic [31:0] model [32];

  int n_checks;
  int n_errors;

  banco_registros_if #(.XLEN(32), .AW(5)) if_b ();
  banco_registros_if #(.XLEN(32), .AW(5)) if_n ();

  assign if_b.WE  = t_we;
  assign if_b.WA  = t_wa;
  assign if_b.WD  = t_wd;
  assign if_b.RA1 = t_ra1;
  assign if_b.RA2 = t_ra2;
  assign if_n.WE  = t_we;
  assign if_n.WA  = t_wa;
  assign if_n.WD  = t_wd;
  assign if_n.RA1 = t_ra1;
  assign if_n.RA2 = t_ra2;

  banco_registros #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) dut_b (
    .CLK (CLK),
    .RST (t_rst),
    .rf  (if_b.slave)
  );

  banco_registros #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) dut_n (
    .CLK (CLK),
    .RST (t_rst),
    .rf  (if_n.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural read rule: x0 reads zero, an accepted same-cycle write forwards, else stored value.
  function automatic logic [31:0] exp_read(input logic [4:0] ra, input bit bypass);
    if (ra == 5'd0) return 32'h0;
    if (bypass && t_we && !t_rst && (t_wa == ra)) return t_wd;
    return model[ra];
  endfunction

  // Present a new set of inputs mid-cycle, away from the active edge.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge CLK);
    t_rst = rst;
    t_we  = we;
    t_wa  = wa;
    t_wd  = wd;
    t_ra1 = ra1;
    t_ra2 = ra2;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_b_rd1"}, if_b.RD1, exp_read(t_ra1, 1'b1));
    chk({tag, "_b_rd2"}, if_b.RD2, exp_read(t_ra2, 1'b1));
    chk({tag, "_n_rd1"}, if_n.RD1, exp_read(t_ra1, 1'b0));
    chk({tag, "_n_rd2"}, if_n.RD2, exp_read(t_ra2, 1'b0));
  endtask

  // Advance through the rising edge and apply the same effect to the model.
  task automatic tick();
    @(posedge CLK);
    if (t_rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (t_we && t_wa != 5'd0) begin
      model[t_wa] = t_wd;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    t_rst = 1'b1; t_we = 1'b0; t_wa = '0; t_wd = '0; t_ra1 = '0; t_ra2 = '0;

    // Reset, then every register reads zero.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 32; i += 4) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
      chk("reset_zero_rd1", if_b.RD1, 32'h0);
      chk("reset_zero_rd2", if_n.RD2, 32'h0);
    end

    // x5 write, visible one cycle after the edge; x6 still zero.
    drive(1'b0, 1'b1, 5'd5, 32'hABCDEF17, 5'd5, 5'd6);
    check_model("wr_x5");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    chk("x5_b_rd1", if_b.RD1, 32'hABCDEF17);
    chk("x5_n_rd1", if_n.RD1, 32'hABCDEF17);
    chk("x6_b_rd2", if_b.RD2, 32'h0);

    // Writes to x0 are dropped.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("x0_wr_b_rd1", if_b.RD1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("x0_b_rd1", if_b.RD1, 32'h0);
    chk("x0_b_rd2", if_b.RD2, 32'h0);
    chk("x0_n_rd2", if_n.RD2, 32'h0);

    // Same-cycle write/read of x10: forwarded only with bypass.
    drive(1'b0, 1'b1, 5'd10, 32'h000003FF, 5'd0, 5'd10);
    chk("byp_b_rd2", if_b.RD2, 32'h000003FF);
    chk("byp_n_rd2", if_n.RD2, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
    chk("x10_b_rd1", if_b.RD1, 32'h000003FF);
    chk("x10_n_rd2", if_n.RD2, 32'h000003FF);

    // Fill x1..x31, then read complementary pairs.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'h1000 + 32'(i), 5'(i), 5'(32 - i));
      check_model("fill");
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      chk("pair_b_rd1", if_b.RD1, 32'h1000 + 32'(i));
      chk("pair_n_rd2", if_n.RD2, 32'h1000 + 32'(32 - i));
    end

    // Reset cycle with a competing write: no forwarding, old contents shown, then all cleared.
    drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd8);
    tick();
    drive(1'b1, 1'b1, 5'd8, 32'h00000055, 5'd8, 5'd7);
    chk("rstcyc_b_rd1", if_b.RD1, 32'h00001008);
    chk("rstcyc_b_rd2", if_b.RD2, 32'h12345678);
    chk("rstcyc_n_rd1", if_n.RD1, 32'h00001008);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
    chk("postrst_b_x7", if_b.RD1, 32'h0);
    chk("postrst_b_x8", if_b.RD2, 32'h0);
    chk("postrst_n_x8", if_n.RD2, 32'h0);

    // Back-to-back writes to x3: last one wins.
    drive(1'b0, 1'b1, 5'd3, 32'hA, 5'd3, 5'd3);
    tick();
    drive(1'b0, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0);
    chk("b2b_n_first", if_n.RD1, 32'hA);
    chk("b2b_b_fwd", if_b.RD1, 32'hB);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    chk("b2b_b_second", if_b.RD1, 32'hB);
    chk("b2b_n_second", if_n.RD2, 32'hB);

    // Random traffic against the reference model, address range narrowed to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            $urandom(),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      check_model("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
